// File: rtl/pipe_reg_hs_pkg.sv
// Shared parameters and sizing helpers for the pipe_reg_hs pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a. Skid entry enabled by defining PIPE_REG_SKID_EN (off by default):
//   `define PIPE_REG_SKID_EN
package pipe_reg_hs_pkg;

  localparam int DW_DEFAULT = 32;

`ifdef PIPE_REG_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  // Number of words the block can hold: one per stage plus the skid entry.
  function automatic int capacity(input int depth);
    return depth + (SKID_EN ? 1 : 0);
  endfunction

  // Width of the occupancy counter; DEPTH+2 covers the skid build too.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Upstream/downstream handshake bundle for pipe_reg_hs.
// Latency: n/a (wires only).
// Backpressure: carries in_ready_o upstream and out_ready_i from downstream.
interface pipe_reg_hs_if #(
  parameter int DW = 32,
  parameter int OW = 2
);
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [OW-1:0] occ_o;

  // Side that feeds words in and consumes them at the far end.
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occ_o
  );

  // The pipeline register itself.
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occ_o
  );
endinterface

// File: rtl/pipe_reg_hs_stage.sv
// One pipeline stage: valid bit plus data word with load, flush and reset.
// Latency: 1 cycle from load to q/v.
// Backpressure: none locally; the parent drives load from its advance chain.
module pipe_reg_hs_stage #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          vin,
  input  logic [DW-1:0] rst_val,
  output logic [DW-1:0] q,
  output logic          v
);

  // Valid follows the loaded source; data only moves when a real word lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v <= 1'b0;
      q <= rst_val;
    end else begin
      if (flush_i) begin
        v <= 1'b0;
      end else if (load) begin
        v <= vin;
      end
      if (load && vin && !flush_i) begin
        q <= din;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// DEPTH-stage valid/ready pipeline register with flush, bubble collapse, optional skid (PIPE_REG_SKID_EN).
// Latency: DEPTH cycles from accept to out_valid_o when unstalled, 1 word/cycle throughput.
// Backpressure: in_ready_o combinational from out_ready_i; with skid it is registered only.
module pipe_reg_hs
  import pipe_reg_hs_pkg::*;
#(
  parameter int            DW      = DW_DEFAULT,
  parameter int            DEPTH   = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  pipe_reg_hs_if.slave bus
);

  localparam int OW  = occ_width(DEPTH);
  localparam int CAP = capacity(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DW-1:0]    q [DEPTH];
  logic [DW-1:0]    stg_din [DEPTH];
  logic [DEPTH-1:0] stg_vin;
  logic [DW-1:0]    s0_din;
  logic             s0_vin;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic [OW-1:0]    occ;

  // A stage's word leaves when the output drains or any stage ahead of it is empty;
  // a stage takes new data when it is empty or its own word is leaving.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = bus.out_ready_i;
      for (int j = k + 1; j < DEPTH; j++) begin
        if (!v[j]) adv[k] = 1'b1;
      end
      load[k] = !v[k] | adv[k];
    end
  end

  // Stage 0 is fed from the input side, every other stage from its predecessor.
  always_comb begin
    stg_din[0] = s0_din;
    stg_vin[0] = s0_vin;
    for (int k = 1; k < DEPTH; k++) begin
      stg_din[k] = q[k-1];
      stg_vin[k] = v[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_reg_hs_stage #(.DW(DW)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .load    (load[k]),
      .din     (stg_din[k]),
      .vin     (stg_vin[k]),
      .rst_val (RST_VAL),
      .q       (q[k]),
      .v       (v[k])
    );
  end

  assign in_xfer  = bus.in_valid_i & in_ready;
  assign out_xfer = v[DEPTH-1] & bus.out_ready_i;

`ifdef PIPE_REG_SKID_EN
  logic          skid_v;
  logic [DW-1:0] skid_q;

  // Ready depends only on the skid flop, so out_ready_i never reaches in_ready_o.
  assign in_ready = !skid_v & !flush_i;
  assign s0_din   = skid_v ? skid_q : bus.in_data_i;
  assign s0_vin   = skid_v | in_xfer;

  // Park an accepted word when stage 0 is blocked; release it when stage 0 loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_v <= 1'b0;
      skid_q <= RST_VAL;
    end else if (flush_i) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (load[0]) skid_v <= 1'b0;
    end else if (in_xfer && !load[0]) begin
      skid_v <= 1'b1;
      skid_q <= bus.in_data_i;
    end
  end
`else
  assign in_ready = load[0] & !flush_i;
  assign s0_din   = bus.in_data_i;
  assign s0_vin   = in_xfer;
`endif

  // Occupancy tracks accepted minus delivered words; flush and reset empty it.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = v[DEPTH-1];
  assign bus.out_data_o  = q[DEPTH-1];
  assign bus.occ_o       = occ;

  a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.in_valid_i && !in_ready) ##1 bus.in_valid_i |-> $stable(bus.in_data_i));

  a_out_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (v[DEPTH-1] && !bus.out_ready_i && !flush_i) |=> v[DEPTH-1]);

  a_occ_cap: assert property (@(posedge clk_i) int'(occ) <= CAP);

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs: reset, streaming, back-pressure, bubble collapse, flush, reset-over-flush.
// Latency: expects DEPTH=3 cycles accept-to-output.
// Backpressure: exercised by holding out_ready_i low and releasing it.
module tb_pipe_reg_hs;
  import pipe_reg_hs_pkg::*;

  localparam int        DW    = 8;
  localparam int        DEPTH = 3;
  localparam logic [7:0] RV   = 8'hA5;
  localparam int        OW    = occ_width(DEPTH);
  localparam int        CAP   = capacity(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   passes = 0;

  pipe_reg_hs_if #(.DW(DW), .OW(OW)) bus ();

  pipe_reg_hs #(.DW(DW), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  initial begin
    logic [7:0] exp_w;
    int         got;
    logic       accept;

    // Reset
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data",  32'(bus.out_data_o),  32'hA5);
    chk("rst_occ",       32'(bus.occ_o),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);

    // Streaming 0x01..0x10 with out_ready held high: word j+1 offered in cycle j,
    // word j-2 expected at the output in cycle j.
    bus.out_ready_i = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.in_valid_i = (j < 16);
      bus.in_data_i  = 8'(j + 1);
      #1;
      if (j < 16) chk("str_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("str_out_valid", 32'(bus.out_valid_o), (j >= 3 && j <= 18) ? 32'd1 : 32'd0);
      if (j >= 3 && j <= 18) chk("str_out_data", 32'(bus.out_data_o), 32'(j - 2));
      chk("str_occ", 32'(bus.occ_o), (j <= 3) ? 32'(j) : ((j <= 16) ? 32'd3 : 32'(19 - j)));
      tick();
    end
    bus.in_valid_i = 1'b0;

    // Back-pressure: fill to capacity, one more word waits, then drain in order.
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'(8'h21 + k);
      #1;
      chk("bp_fill_ready", 32'(bus.in_ready_o), 32'd1);
      tick();
    end
    bus.in_data_i = 8'(8'h21 + CAP);
    #1;
    chk("bp_full_ready", 32'(bus.in_ready_o),  32'd0);
    chk("bp_full_occ",   32'(bus.occ_o),       32'(CAP));
    chk("bp_full_valid", 32'(bus.out_valid_o), 32'd1);
    chk("bp_head_data",  32'(bus.out_data_o),  32'h21);
    tick();
    chk("bp_stall_ready", 32'(bus.in_ready_o), 32'd0);
    chk("bp_stall_occ",   32'(bus.occ_o),      32'(CAP));
    bus.out_ready_i = 1'b1;
    exp_w = 8'h21;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_valid_o) begin
        chk("bp_drain_data", 32'(bus.out_data_o), 32'(exp_w));
        exp_w = exp_w + 8'd1;
        got++;
      end
      accept = bus.in_valid_i & bus.in_ready_o;
      tick();
      if (accept) bus.in_valid_i = 1'b0;
    end
    chk("bp_drain_count", 32'(got), 32'(CAP + 1));
    chk("bp_drain_occ",   32'(bus.occ_o), 32'd0);

    // Bubble collapse: second word joins two cycles later behind a stalled head.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 8'h51;
    #1;
    chk("bub_ready0", 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'h52;
    #1;
    chk("bub_ready1", 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    chk("bub_occ",      32'(bus.occ_o),       32'd2);
    chk("bub_valid",    32'(bus.out_valid_o), 32'd1);
    chk("bub_head",     32'(bus.out_data_o),  32'h51);
    chk("bub_in_ready", 32'(bus.in_ready_o),  32'd1);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bub_out0", 32'(bus.out_data_o), 32'h51);
    tick();
    chk("bub_valid1", 32'(bus.out_valid_o), 32'd1);
    chk("bub_out1",   32'(bus.out_data_o),  32'h52);
    tick();
    chk("bub_empty", 32'(bus.out_valid_o), 32'd0);
    chk("bub_occ0",  32'(bus.occ_o),       32'd0);

    // Flush with occupancy 3 and the head transferring in the flush cycle.
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'(8'h61 + k);
      tick();
    end
    bus.in_valid_i = 1'b0;
    chk("fl_pre_occ", 32'(bus.occ_o), 32'd3);
    flush = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 8'h77;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready_o),  32'd0);
    chk("fl_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("fl_out_data", 32'(bus.out_data_o),  32'h61);
    tick();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    #1;
    chk("fl_post_valid", 32'(bus.out_valid_o), 32'd0);
    chk("fl_post_occ",   32'(bus.occ_o),       32'd0);
    chk("fl_post_ready", 32'(bus.in_ready_o),  32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fl_no_77", 32'(bus.out_valid_o), 32'd0);
    end

    // Reset wins over a simultaneous flush and reloads data with RST_VAL.
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'(8'h71 + k);
      tick();
    end
    bus.in_valid_i = 1'b0;
    chk("rf_head", 32'(bus.out_data_o), 32'h71);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    #1;
    chk("rf_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rf_out_data",  32'(bus.out_data_o),  32'hA5);
    chk("rf_occ",       32'(bus.occ_o),       32'd0);
    chk("rf_in_ready",  32'(bus.in_ready_o),  32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
